// File: rtl/grid_pkg.sv
// Shared definitions for the maze grid value store: grid geometry, cell value
// encodings and controller states.
package grid_pkg;

  localparam int GRID_COLS  = 16;
  localparam int GRID_ROWS  = 15;
  localparam int CELL_SHIFT = 5;
  localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;  // 240

  localparam int ADDR_W  = 8;
  localparam int VAL_W   = 2;
  localparam int COORD_W = 10;
  localparam int IDX_W   = 4;

  // Last valid cell address and last valid cell row.
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(GRID_CELLS - 1);
  localparam logic [IDX_W-1:0]   LAST_ROW  = IDX_W'(GRID_ROWS - 1);
  // First scan line below the visible area (480).
  localparam logic [COORD_W-1:0] V_ACTIVE  = COORD_W'(GRID_ROWS << CELL_SHIFT);

  // Cell value encodings.
  localparam logic [VAL_W-1:0] VAL_UNEXPLORED = 2'b00;
  localparam logic [VAL_W-1:0] VAL_WALL       = 2'b01;
  localparam logic [VAL_W-1:0] VAL_PATH       = 2'b10;
  localparam logic [VAL_W-1:0] VAL_ROBOT      = 2'b11;

  typedef enum logic {
    ST_CLEARING = 1'b0,
    ST_IDLE     = 1'b1
  } state_e;

  // Row-major cell address: row*16 + col.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [IDX_W-1:0] row,
                                                  input logic [IDX_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/grid_ram.sv
// 240x2 simple dual-port RAM: one write port, one registered read port.
// Reads of an address being written in the same cycle return the old data.
module grid_ram
  import grid_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [VAL_W-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [VAL_W-1:0]  rdata_o
);

  logic [VAL_W-1:0] mem_q [GRID_CELLS];
  logic [VAL_W-1:0] rdata_q;

  // Write port and registered read port; addresses past the last cell are inert.
  // NOTE: the array has no reset -- contents are cleared by the controller's sweep,
  // which keeps this mappable onto block/distributed RAM.
  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i <= LAST_ADDR)) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= (raddr_i <= LAST_ADDR) ? mem_q[raddr_i] : VAL_UNEXPLORED;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/grid_value_store.sv
// Maze grid value store: 16x15 cells of 2-bit values, written by the robot
// update path over a valid/ready handshake and read every pixel clock by the
// VGA scan coordinates with one cycle of latency.
// Optional macro GRID_FRAME_SYNC_EN: accepted writes are held in a one-entry
// pending register and only committed during vertical blank.
module grid_value_store
  import grid_pkg::*;
(
  input  logic               CLOCK_25,
  input  logic               RESET,
  input  logic               WR_VALID,
  output logic               WR_READY,
  input  logic [IDX_W-1:0]   WR_X,
  input  logic [IDX_W-1:0]   WR_Y,
  input  logic [VAL_W-1:0]   WR_VALUE,
  input  logic               CLEAR_REQ,
  output logic               BUSY,
  input  logic [COORD_W-1:0] X_COORD,
  input  logic [COORD_W-1:0] Y_COORD,
  output logic [VAL_W-1:0]   VALUE_OUT,
  output logic [COORD_W-1:0] X_COORD_D,
  output logic [COORD_W-1:0] Y_COORD_D
);

  state_e             state_q;
  logic [ADDR_W-1:0]  sweep_q;
  logic               busy_q;

  logic               wr_fire;
  logic               wr_in_range;
  logic               vblank;
  logic               commit;
  logic [ADDR_W-1:0]  commit_addr;
  logic [VAL_W-1:0]   commit_data;

  logic               ram_we;
  logic [ADDR_W-1:0]  ram_waddr;
  logic [VAL_W-1:0]   ram_wdata;
  logic [ADDR_W-1:0]  ram_raddr;
  logic [VAL_W-1:0]   ram_rdata;

  logic               blank_d, blank_q;
  logic [COORD_W-1:0] x_d_q, y_d_q;

  assign wr_in_range = (WR_Y <= LAST_ROW);
  assign vblank      = (Y_COORD >= V_ACTIVE);
  assign wr_fire     = WR_VALID && WR_READY;

  // Controller: clear sweep after reset or CLEAR_REQ, otherwise idle.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_CLEARING;
      sweep_q <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEARING: begin
          if (sweep_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            sweep_q <= '0;
            busy_q  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + 8'd1;
          end
        end
        ST_IDLE: begin
          if (CLEAR_REQ) begin
            state_q <= ST_CLEARING;
            sweep_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_CLEARING;
          sweep_q <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign BUSY = busy_q;

`ifdef GRID_FRAME_SYNC_EN
  logic              pend_valid_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [VAL_W-1:0]  pend_data_q;

  // Pending write: loaded on an in-range handshake, drained in vertical blank,
  // discarded by a clear request.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= VAL_UNEXPLORED;
    end else if (CLEAR_REQ) begin
      pend_valid_q <= 1'b0;
    end else if (commit) begin
      pend_valid_q <= 1'b0;
    end else if (wr_fire && wr_in_range) begin
      pend_valid_q <= 1'b1;
      pend_addr_q  <= cell_addr(WR_Y, WR_X);
      pend_data_q  <= WR_VALUE;
    end
  end

  assign WR_READY    = (state_q == ST_IDLE) && !CLEAR_REQ && !pend_valid_q;
  assign commit      = pend_valid_q && vblank && (state_q == ST_IDLE);
  assign commit_addr = pend_addr_q;
  assign commit_data = pend_data_q;
`else
  assign WR_READY    = (state_q == ST_IDLE) && !CLEAR_REQ;
  assign commit      = wr_fire && wr_in_range;
  assign commit_addr = cell_addr(WR_Y, WR_X);
  assign commit_data = WR_VALUE;
`endif

  // RAM write port: the clear sweep owns it while clearing, commits otherwise.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = sweep_q;
    ram_wdata = VAL_UNEXPLORED;
    if (state_q == ST_CLEARING) begin
      ram_we = 1'b1;
    end else if (commit) begin
      ram_we    = 1'b1;
      ram_waddr = commit_addr;
      ram_wdata = commit_data;
    end
  end

  assign ram_raddr = cell_addr(Y_COORD[CELL_SHIFT+IDX_W-1:CELL_SHIFT],
                               X_COORD[CELL_SHIFT+IDX_W-1:CELL_SHIFT]);

  grid_ram u_ram (
    .clk_i   (CLOCK_25),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // Pixels outside the grid, or any read during a sweep, show as unexplored.
  assign blank_d = X_COORD[COORD_W-1] || vblank || (state_q == ST_CLEARING);

  // Read-side pipeline: blanking flag and coordinates aligned with RAM data.
  always_ff @(posedge CLOCK_25 or posedge RESET) begin
    if (RESET) begin
      blank_q <= 1'b1;
      x_d_q   <= '0;
      y_d_q   <= '0;
    end else begin
      blank_q <= blank_d;
      x_d_q   <= X_COORD;
      y_d_q   <= Y_COORD;
    end
  end

  assign VALUE_OUT = blank_q ? VAL_UNEXPLORED : ram_rdata;
  assign X_COORD_D = x_d_q;
  assign Y_COORD_D = y_d_q;

endmodule
